// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM states, mode encodings
// and the chip-select index width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cs_idx_w(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timebase: tick is high on the last of div+1 cycles after a restart.
// The counter clears on restart and on every tick, so each phase lasts exactly div+1 cycles.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == div);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with runtime mode, divider and chip-select choice.
// Transfer is IDLE -> SETUP (H) -> 2*DATA_W SCLK edges (H apart) -> HOLD (H) -> done.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [DATA_W-1:0]               tx_data,
  input  logic                            tx_start,
  input  logic [cs_idx_w(NUM_CS)-1:0]     cs_sel,
  input  logic [DIV_W-1:0]                clk_div,
  input  logic                            cpol,
  input  logic                            cpha,
  output logic                            busy,
  output logic [DATA_W-1:0]               rx_data,
  output logic                            tx_done,
  output logic                            spi_sclk,
  output logic                            spi_mosi,
  input  logic                            spi_miso,
  output logic [NUM_CS-1:0]               spi_cs_n
);

  localparam int EW = $clog2(2*DATA_W+1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_W);

  state_t            state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DIV_W-1:0]  div_q;
  logic              cpha_q;
  logic [EW-1:0]     edge_cnt;
  logic [EW-1:0]     edge_nxt;
  logic              tick;
  logic              leading;
  logic              capture;
  logic              drive;

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk     (clk),
    .resetn  (resetn),
    .restart (state == ST_IDLE),
    .div     (div_q),
    .tick    (tick)
  );

  // Odd edges lead away from CPOL; CPHA picks which half samples and which drives.
  // In mode 0/2 the MSB is already on MOSI, so the final trailing edge drives nothing.
  assign edge_nxt = edge_cnt + 1'b1;
  assign leading  = edge_nxt[0];
  assign capture  = leading ^ cpha_q;
  assign drive    = cpha_q ? leading : (!leading && (edge_nxt != LAST_EDGE));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      rx_data  <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= '1;
      tx_sr    <= '0;
      rx_sr    <= '0;
      div_q    <= '0;
      cpha_q   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          spi_sclk <= cpol;
          spi_mosi <= 1'b0;
          if (tx_start) begin
            state    <= ST_SETUP;
            busy     <= 1'b1;
            div_q    <= clk_div;
            cpha_q   <= cpha;
            edge_cnt <= '0;
            // Out-of-range index shifts the one-hot out, leaving every CS high.
            spi_cs_n <= ~(NUM_CS'(1) << cs_sel);
            spi_mosi <= cpha ? 1'b0 : tx_data[DATA_W-1];
            tx_sr    <= cpha ? tx_data : (tx_data << 1);
          end
        end
        ST_SETUP, ST_XFER: begin
          if (tick) begin
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_nxt;
            if (capture) begin
              rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
            end
            if (drive) begin
              spi_mosi <= tx_sr[DATA_W-1];
              tx_sr    <= tx_sr << 1;
            end
            state <= (edge_nxt == LAST_EDGE) ? ST_HOLD : ST_XFER;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tx_done  <= 1'b1;
            rx_data  <= rx_sr;
            spi_cs_n <= '1;
            spi_mosi <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: table-driven and random transfers against
// an edge-schedule / SPI-slave model, plus back-to-back, busy-drop and reset-abort sequences.
module tb_spi_master_cfg;
  import spi_pkg::*;

  localparam int W   = 8;
  localparam int NCS = 5;

  logic       clk = 0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [2:0] cs_sel;
  logic [7:0] clk_div;
  logic       cpol;
  logic       cpha;
  logic       busy;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [4:0] spi_cs_n;

  logic loopback = 1'b0;
  logic miso_drv = 1'b0;
  assign spi_miso = loopback ? spi_mosi : miso_drv;

  int checks = 0;
  int failures = 0;
  int gcyc = 0;
  int start_gc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  spi_master_cfg #(.DATA_W(W), .NUM_CS(NCS), .DIV_W(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .cs_sel   (cs_sel),
    .clk_div  (clk_div),
    .cpol     (cpol),
    .cpha     (cpha),
    .busy     (busy),
    .rx_data  (rx_data),
    .tx_done  (tx_done),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] div;
    logic [2:0] cs;
    logic [1:0] mode;
    logic       lb;
    logic [7:0] sw;
    logic [7:0] exp_rx;
    logic [4:0] exp_cs;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one transfer, acting as an SPI slave and checking the edge schedule.
  task automatic xfer(input vec_t v, input bit chained, input int poke_c, output int done_c);
    int h, k, sbit, bad_mosi, bad_hold, edge_ok, budget;
    logic psclk, pmosi, sedge, sclk_chg, cpha_v, busy1;
    logic [7:0] got;
    logic [4:0] cs1;
    h = int'(v.div) + 1;
    cpha_v = v.mode[0];
    loopback = v.lb;
    cpol = v.mode[1];
    if (!chained) begin
      repeat (2) @(negedge clk);
      check("idle_sclk", {31'd0, spi_sclk}, {31'd0, v.mode[1]});
    end
    tx_data = v.data; clk_div = v.div; cs_sel = v.cs; cpha = cpha_v; tx_start = 1'b1;
    psclk = spi_sclk; pmosi = spi_mosi;
    k = 0; sbit = 0; bad_mosi = 0; bad_hold = 0; edge_ok = 1; got = '0; done_c = -1;
    cs1 = '0; busy1 = 1'b0; miso_drv = 1'b0;
    budget = 1 + (2*W+1)*h + 8;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      tx_start = (c == poke_c);
      if (c == poke_c) begin
        tx_data = ~v.data; cs_sel = v.cs + 3'd1; clk_div = 8'd0; cpha = ~cpha_v; cpol = ~cpol;
      end
      if (c == 1) begin
        cs1 = spi_cs_n; busy1 = busy; start_gc = gcyc;
        if (!cpha_v) begin miso_drv = v.sw[W-1]; sbit = 1; end
      end
      sedge = 1'b0;
      sclk_chg = (spi_sclk !== psclk);
      if (sclk_chg) begin
        k++;
        if (c != 1 + k*h) edge_ok = 0;
        sedge = (((k % 2) == 1) == !cpha_v);
        if (sedge) got = {got[6:0], spi_mosi};
        else if (sbit < W) begin miso_drv = v.sw[W-1-sbit]; sbit++; end
      end
      if ((spi_mosi !== pmosi) && !(c == 1 && !cpha_v) && !(sclk_chg && !sedge) && !tx_done)
        bad_mosi++;
      if (!tx_done && (busy !== 1'b1 || spi_cs_n !== v.exp_cs)) bad_hold++;
      psclk = spi_sclk; pmosi = spi_mosi;
      if (tx_done) begin done_c = c; break; end
    end
    tx_start = 1'b0;
    cpol = v.mode[1];
    check("cs_start", {27'd0, cs1}, {27'd0, v.exp_cs});
    check("busy_start", {31'd0, busy1}, 32'd1);
    check("sclk_edge_count", k, 2*W);
    check("sclk_edge_timing", edge_ok, 1);
    check("mosi_edge_phase", bad_mosi, 0);
    check("busy_cs_held", bad_hold, 0);
    check("slave_got_mosi", {24'd0, got}, {24'd0, v.data});
    check("done_cycle", done_c, 1 + (2*W+1)*h);
    if (done_c > 0) begin
      check("rx_data", {24'd0, rx_data}, {24'd0, v.exp_rx});
      check("cs_done", {27'd0, spi_cs_n}, 32'h1f);
      check("busy_done", {31'd0, busy}, 32'd0);
      check("sclk_done", {31'd0, spi_sclk}, {31'd0, v.mode[1]});
    end
  endtask

  function automatic logic [4:0] model_cs(input logic [2:0] cs);
    logic [4:0] r;
    for (int i = 0; i < NCS; i++) r[i] = (i != int'(cs));
    return r;
  endfunction

  initial begin
    int d1, d2, g1, nd;
    vec_t v;
    resetn = 0; tx_data = 0; tx_start = 0; cs_sel = 0; clk_div = 0; cpol = 0; cpha = 0;
    tbl[0] = '{8'hA5, 8'd3, 3'd2, MODE0, 1'b1, 8'h00, 8'hA5, 5'b11011};
    tbl[1] = '{8'hC3, 8'd2, 3'd0, MODE1, 1'b0, 8'h3C, 8'h3C, 5'b11110};
    tbl[2] = '{8'hC3, 8'd1, 3'd1, MODE2, 1'b0, 8'h3C, 8'h3C, 5'b11101};
    tbl[3] = '{8'hC3, 8'd4, 3'd3, MODE3, 1'b0, 8'h3C, 8'h3C, 5'b10111};
    tbl[4] = '{8'h5A, 8'd2, 3'd5, MODE0, 1'b0, 8'h96, 8'h96, 5'b11111};
    tbl[5] = '{8'h0F, 8'd0, 3'd4, MODE3, 1'b1, 8'h00, 8'h0F, 5'b01111};
    tbl[6] = '{8'h33, 8'd1, 3'd7, MODE1, 1'b0, 8'hE1, 8'hE1, 5'b11111};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_rx", {24'd0, rx_data}, 32'd0);
    check("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    check("rst_cs", {27'd0, spi_cs_n}, 32'h1f);
    resetn = 1;

    for (int i = 0; i < 7; i++) xfer(tbl[i], 1'b0, -1, d1);

    // Random transfers checked against the slave model
    for (int i = 0; i < 12; i++) begin
      v.data = 8'($urandom);
      v.div  = 8'($urandom_range(0, 5));
      v.cs   = 3'($urandom_range(0, 7));
      v.mode = 2'($urandom_range(0, 3));
      v.lb   = 1'($urandom_range(0, 1));
      v.sw   = 8'($urandom);
      v.exp_rx = v.lb ? v.data : v.sw;
      v.exp_cs = model_cs(v.cs);
      xfer(v, 1'b0, -1, d1);
    end

    // Back-to-back at clk/2: second start in the cycle after done, 1-cycle CS gap
    v = '{8'h01, 8'd0, 3'd0, MODE0, 1'b1, 8'h00, 8'h01, 5'b11110};
    xfer(v, 1'b0, -1, d1);
    g1 = gcyc;
    v = '{8'h80, 8'd0, 3'd3, MODE0, 1'b1, 8'h00, 8'h80, 5'b10111};
    xfer(v, 1'b1, -1, d2);
    check("b2b_cs_gap", start_gc - g1, 1);

    // tx_start at cycle 20 while busy is dropped; no second transfer follows
    v = '{8'h6D, 8'd3, 3'd1, MODE2, 1'b0, 8'hB4, 8'hB4, 5'b11101};
    xfer(v, 1'b0, 20, d1);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_done || busy) nd++;
    end
    check("busy_start_dropped", nd, 0);

    // Reset at cycle 30 aborts at once with no done
    @(negedge clk);
    cpol = 1; cpha = 0; tx_data = 8'h96; clk_div = 8'd3; cs_sel = 3'd1; loopback = 1; tx_start = 1;
    @(negedge clk);
    tx_start = 0;
    repeat (29) @(negedge clk);
    resetn = 0;
    #1;
    check("abort_cs", {27'd0, spi_cs_n}, 32'h1f);
    check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_done) nd++;
    end
    check("abort_no_done", nd, 0);
    resetn = 1;
    xfer(tbl[0], 1'b0, -1, d1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
